// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : memory_arbiter
//  Purpose  : Round-robin sharing of one memory_unit command port between N
//             requesters, with GC hand-off and transparent GET_FREE retry.
//  Revision : 1.0
// ============================================================================
module memory_arbiter #(
    parameter int N      = 3,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int IDW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          i_req_valid,
    input  logic [2*N-1:0]        i_req_func,
    input  logic [N*ADDR_W-1:0]   i_req_addr1,
    input  logic [N*ADDR_W-1:0]   i_req_addr2,
    input  logic [N*DATA_W-1:0]   i_req_wdata,
    output logic [N-1:0]          o_req_done,
    output logic [IDW-1:0]        o_grant_id,
    output logic [DATA_W-1:0]     o_rsp_data1,
    output logic [DATA_W-1:0]     o_rsp_data2,
    output logic [ADDR_W-1:0]     o_rsp_free_addr,
    output logic                  o_gc_busy,
    output logic                  o_gc_done,
    output logic [ADDR_W-1:0]     o_gc_root,
    output logic                  o_oom,
    output logic [1:0]            o_mem_func,
    output logic                  o_mem_execute,
    output logic [ADDR_W-1:0]     o_mem_address1,
    output logic [ADDR_W-1:0]     o_mem_address2,
    output logic [DATA_W-1:0]     o_mem_write_data,
    output logic                  o_mem_gc_ready,
    input  logic                  i_mem_is_ready,
    input  logic                  i_mem_gc,
    input  logic [DATA_W-1:0]     i_mem_read_data1,
    input  logic [DATA_W-1:0]     i_mem_read_data2,
    input  logic [ADDR_W-1:0]     i_mem_free_addr
);

    localparam logic [1:0] c_GET_FREE = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_SETTLE = 3'd2,
        S_WAIT   = 3'd3,
        S_GC_ARM = 3'd4,
        S_GC_RUN = 3'd5
    } state_t;

    state_t r_state, w_state_nxt;

    logic [IDW-1:0]    r_rr_ptr, r_grant_id, w_winner, w_ptr_nxt;
    logic              r_retry, w_any;
    logic [N-1:0]      r_req_done;
    logic [DATA_W-1:0] r_rsp_data1, r_rsp_data2, r_mem_write_data;
    logic [ADDR_W-1:0] r_rsp_free_addr, r_gc_root, r_mem_address1, r_mem_address2;
    logic              r_gc_busy, r_gc_done, r_oom, r_mem_execute, r_mem_gc_ready;
    logic [1:0]        r_mem_func;
    logic              w_grant, w_complete, w_oom_fail, w_gc_enter, w_gc_finish;

    logic [1:0]        w_func  [N];
    logic [ADDR_W-1:0] w_addr1 [N];
    logic [ADDR_W-1:0] w_addr2 [N];
    logic [DATA_W-1:0] w_wdata [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign w_func[g]  = i_req_func[2*g +: 2];
        assign w_addr1[g] = i_req_addr1[g*ADDR_W +: ADDR_W];
        assign w_addr2[g] = i_req_addr2[g*ADDR_W +: ADDR_W];
        assign w_wdata[g] = i_req_wdata[g*DATA_W +: DATA_W];
    end

    // Scan downwards so the lowest offset from the pointer wins last.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req_valid[(int'(r_rr_ptr) + k) % N]) begin
                w_any    = 1'b1;
                w_winner = IDW'((int'(r_rr_ptr) + k) % N);
            end
        end
    end

    assign w_ptr_nxt = (r_grant_id == IDW'(N - 1)) ? '0 : r_grant_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_complete  = 1'b0;
        w_oom_fail  = 1'b0;
        w_gc_enter  = 1'b0;
        w_gc_finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_mem_gc) begin
                    w_gc_enter  = 1'b1;
                    w_state_nxt = S_GC_ARM;
                end else if (i_mem_is_ready && w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE:  w_state_nxt = S_SETTLE;
            S_SETTLE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (i_mem_is_ready) begin
                    if (r_mem_func == c_GET_FREE && i_mem_gc) begin
                        if (!r_retry) begin
                            w_gc_enter  = 1'b1;
                            w_state_nxt = S_GC_ARM;
                        end else begin
                            w_oom_fail  = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_complete  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_GC_ARM: w_state_nxt = S_GC_RUN;
            // is_ready stays high through GC, so only the fall of gc ends it.
            S_GC_RUN: begin
                if (!i_mem_gc) begin
                    w_gc_finish = 1'b1;
                    w_state_nxt = r_retry ? S_ISSUE : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr         <= '0;
            r_grant_id       <= '0;
            r_retry          <= 1'b0;
            r_req_done       <= '0;
            r_rsp_data1      <= '0;
            r_rsp_data2      <= '0;
            r_rsp_free_addr  <= '0;
            r_gc_busy        <= 1'b0;
            r_gc_done        <= 1'b0;
            r_gc_root        <= '0;
            r_oom            <= 1'b0;
            r_mem_func       <= '0;
            r_mem_execute    <= 1'b0;
            r_mem_address1   <= '0;
            r_mem_address2   <= '0;
            r_mem_write_data <= '0;
            r_mem_gc_ready   <= 1'b0;
        end else begin
            r_req_done    <= '0;
            r_gc_done     <= 1'b0;
            r_mem_execute <= (w_state_nxt == S_ISSUE);
            if (w_grant) begin
                r_grant_id       <= w_winner;
                r_mem_func       <= w_func[w_winner];
                r_mem_address1   <= w_addr1[w_winner];
                r_mem_address2   <= w_addr2[w_winner];
                r_mem_write_data <= w_wdata[w_winner];
            end
            if (w_complete) begin
                r_rsp_data1             <= i_mem_read_data1;
                r_rsp_data2             <= i_mem_read_data2;
                r_rsp_free_addr         <= i_mem_free_addr;
                r_req_done[r_grant_id]  <= 1'b1;
                r_rr_ptr                <= w_ptr_nxt;
                r_retry                 <= 1'b0;
            end
            if (w_oom_fail) begin
                r_oom                   <= 1'b1;
                r_rsp_free_addr         <= '0;
                r_req_done[r_grant_id]  <= 1'b1;
                r_rr_ptr                <= w_ptr_nxt;
                r_retry                 <= 1'b0;
            end
            // Only a GC entered from a failed allocation is followed by a retry.
            if (w_gc_enter) begin
                r_gc_busy      <= 1'b1;
                r_mem_gc_ready <= 1'b1;
                r_retry        <= (r_state == S_WAIT);
            end
            if (w_gc_finish) begin
                r_gc_busy      <= 1'b0;
                r_mem_gc_ready <= 1'b0;
                r_gc_done      <= 1'b1;
                r_gc_root      <= i_mem_read_data1[ADDR_W-1:0];
            end
        end
    end

    assign o_req_done       = r_req_done;
    assign o_grant_id       = r_grant_id;
    assign o_rsp_data1      = r_rsp_data1;
    assign o_rsp_data2      = r_rsp_data2;
    assign o_rsp_free_addr  = r_rsp_free_addr;
    assign o_gc_busy        = r_gc_busy;
    assign o_gc_done        = r_gc_done;
    assign o_gc_root        = r_gc_root;
    assign o_oom            = r_oom;
    assign o_mem_func       = r_mem_func;
    assign o_mem_execute    = r_mem_execute;
    assign o_mem_address1   = r_mem_address1;
    assign o_mem_address2   = r_mem_address2;
    assign o_mem_write_data = r_mem_write_data;
    assign o_mem_gc_ready   = r_mem_gc_ready;

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares one memory_unit command port between N requesters, e.g. the nock evaluator, the noun traverser and the loader.
- Arbitrates round-robin and sequences the execute/is_ready handshake.
- Returns read data and free addresses to the winning requester.
- When a GET_FREE triggers garbage collection, grants GC, broadcasts the relocated root, then transparently retries the allocation.

Parameters:
N, 3, number of requesters (2..8)
ADDR_W, 10, memory address width (matches memory_addr_width)
DATA_W, 64, memory word width (matches memory_data_width)
IDW, 2, grant index width, ceil(log2 N)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock domain (clk), reset asynchronous and active-low
req_valid  in  N  per-requester request; held with operands until that requester's req_done
req_func  in  2N  per-requester func (GET_CONTENTS, SET_CONTENTS, GET_FREE), slice i = [2i+1:2i]
req_addr1  in  N*ADDR_W  per-requester address1
req_addr2  in  N*ADDR_W  per-requester address2
req_wdata  in  N*DATA_W  per-requester write_data (cell word, or cell count for GET_FREE)
req_done  out  N  one-cycle completion pulse to the granted requester
grant_id  out  IDW  index of current or last grant
rsp_data1  out  DATA_W  captured read_data1
rsp_data2  out  DATA_W  captured read_data2
rsp_free_addr  out  ADDR_W  captured free_addr
gc_busy  out  1  high from GC arm until gc_done
gc_done  out  1  one-cycle pulse when GC finishes
gc_root  out  ADDR_W  new root after GC, from read_data1[ADDR_W-1:0]
oom  out  1  sticky; a GET_FREE still failed after a GC
mem_func  out  2  memory_unit func
mem_execute  out  1  memory_unit execute
mem_address1  out  ADDR_W  memory_unit address1
mem_address2  out  ADDR_W  memory_unit address2
mem_write_data  out  DATA_W  memory_unit write_data
mem_gc_ready  out  1  memory_unit gc_ready
mem_is_ready  in  1  memory_unit is_ready
mem_gc  in  1  memory_unit gc
mem_read_data1  in  DATA_W  memory_unit read_data1
mem_read_data2  in  DATA_W  memory_unit read_data2
mem_free_addr  in  ADDR_W  memory_unit free_addr

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer 0, retry flag 0, oom 0.
- Reset mid-operation aborts the command; requesters must re-request.
- All mem_* outputs are registered and held stable from grant until return to IDLE.
- IDLE:
  - If mem_gc=1: go to GC_ARM with retry flag 0.
  - Else if mem_is_ready=1 and any req_valid: winner is the first set bit at or after the rr pointer, wrapping modulo N.
  - On a grant: latch the winner's func/addr1/addr2/wdata onto mem_*, set grant_id, go to ISSUE.
- ISSUE: mem_execute=1 for exactly one cycle, then SETTLE.
- SETTLE: mem_execute=0; one cycle so memory_unit clears is_ready; then WAIT.
- WAIT: on mem_is_ready=1:
  - If mem_func=GET_FREE and mem_gc=1:
    - Retry flag 0: go to GC_ARM, retry flag 1.
    - Retry flag 1: set oom, rsp_free_addr=0 (NIL), pulse req_done, go to IDLE.
  - Otherwise: capture rsp_data1/2 and rsp_free_addr, pulse req_done[grant_id], set rr pointer = grant_id+1 mod N, clear retry flag, go to IDLE.
- GC_ARM: assert mem_gc_ready and gc_busy, then GC_RUN. is_ready stays high during GC, so it is not a progress indicator.
- GC_RUN: hold mem_gc_ready until mem_gc falls. Then drop mem_gc_ready, capture gc_root, pulse gc_done, drop gc_busy.
  - Retry flag 1: return to ISSUE with the latched operands unchanged.
  - Retry flag 0: go to IDLE.
- Latency:
  - Uncontended GET_CONTENTS: req_valid to req_done = 6 cycles (IDLE, ISSUE, SETTLE, 2 memory cycles, capture).
  - SET_CONTENTS: same 6 cycles.
  - GET_FREE hit: 5 cycles.
- A requester may re-request the cycle after req_done; it then competes with the updated pointer.
- Dropping req_valid before req_done is illegal. The command still completes and req_done still pulses.
- Simultaneous requests: exactly one grant per transaction; no requester waits more than N-1 transactions.
- While gc_busy=1, no new grants. Requesters holding old pointers must relocate them using gc_root on gc_done.

Test Plan:
- Single requester 0 GET_CONTENTS addr1=0x05, addr2=0x06 -> exactly one mem_execute pulse; req_done[0] 6 cycles after req_valid; rsp_data1/2 equal the memory words.
- Requesters 0,1,2 all valid, pointer 0 -> grants 0,1,2,0 in order; never two req_done pulses in the same cycle.
- Requester 1 SET_CONTENTS 0x12 <= 0xDEADBEEF, then requester 2 GET_CONTENTS 0x12 -> rsp_data1 = 0xDEADBEEF.
- GET_FREE with wdata exceeding remaining space -> gc_busy, mem_gc_ready held until mem_gc falls; gc_done with gc_root = new root; second mem_execute with identical operands; req_done with a valid rsp_free_addr; oom=0.
- GET_FREE that still fails after GC -> oom=1, rsp_free_addr=0, req_done pulses, arbiter back in IDLE.
- Assert rst low while in WAIT -> all outputs 0 immediately; after release, a fresh request completes normally.
